// File: rtl/neuralcore_pkg.sv
// rtl/neuralcore_pkg.sv - shared loader state type and frame-size helper
package neuralcore_pkg;

    typedef enum logic [1:0] {LD_FILL, LD_START, LD_WAIT} ld_state_t;

    function automatic int frame_len(input int row, input int col);
        return row * col;
    endfunction

endpackage

// File: rtl/image_buffer_ram.sv
// rtl/image_buffer_ram.sv - simple dual-port frame RAM, one write, one registered read
// Read data holds while re is low; a same-address write returns the old word.
module image_buffer_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic                     rzero,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // rzero lets the owner force zero for addresses outside the frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rzero ? '0 : mem[raddr];
        end
    end

endmodule

// File: rtl/image_buffer_loader.sv
// rtl/image_buffer_loader.sv - pixel stream to frame RAM loader feeding the window slider
// IMG_PINGPONG_EN selects double-buffered banks; undefined gives a single bank.
module image_buffer_loader
    import neuralcore_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int DATA_ADDR_WIDTH = 10,
    parameter int IMAGE_ROW_LEN   = 32,
    parameter int IMAGE_COL_LEN   = 32,
    parameter int FRAME_LEN       = frame_len(IMAGE_ROW_LEN, IMAGE_COL_LEN)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [DATA_WIDTH-1:0]      s_data,
    input  logic                       s_last,
    output logic                       ws_start,
    input  logic [DATA_ADDR_WIDTH-1:0] ws_ram_r_addr,
    input  logic                       ws_ram_r_wen,
    output logic [DATA_WIDTH-1:0]      ws_ram_r_data,
    input  logic                       core_done,
    output logic                       frame_err,
    output logic [15:0]                frame_cnt
);

`ifdef IMG_PINGPONG_EN
    localparam int RAM_AW = DATA_ADDR_WIDTH + 1;
`else
    localparam int RAM_AW = DATA_ADDR_WIDTH;
`endif
    localparam int RAM_DEPTH = 1 << RAM_AW;
    localparam logic [DATA_ADDR_WIDTH-1:0] LAST_PTR  = DATA_ADDR_WIDTH'(FRAME_LEN - 1);
    localparam logic [DATA_ADDR_WIDTH:0]   FRAME_LIM = (DATA_ADDR_WIDTH + 1)'(FRAME_LEN);

    ld_state_t                  state;
    logic [DATA_ADDR_WIDTH-1:0] wr_ptr;
    logic                       accept;
    logic                       last_beat;
    logic                       rd_oob;
    logic [RAM_AW-1:0]          ram_waddr;
    logic [RAM_AW-1:0]          ram_raddr;

    assign accept    = s_valid & s_ready;
    assign last_beat = accept && (wr_ptr == LAST_PTR);
    assign rd_oob    = {1'b0, ws_ram_r_addr} >= FRAME_LIM;

`ifdef IMG_PINGPONG_EN
    logic wr_bank;
    logic rd_bank;
    logic wr_full;

    assign ram_waddr = {wr_bank, wr_ptr};
    assign ram_raddr = {rd_bank, ws_ram_r_addr};
`else
    assign ram_waddr = wr_ptr;
    assign ram_raddr = ws_ram_r_addr;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= LD_FILL;
            wr_ptr    <= '0;
            s_ready   <= 1'b0;
            ws_start  <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
`ifdef IMG_PINGPONG_EN
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b1;
            wr_full   <= 1'b0;
`endif
        end else begin
            ws_start  <= 1'b0;
            frame_err <= 1'b0;
            // a final beat always closes the frame; an early s_last discards it
            if (accept) begin
                wr_ptr    <= (last_beat || s_last) ? '0 : wr_ptr + 1'b1;
                frame_err <= last_beat ? ~s_last : s_last;
            end
            case (state)
                LD_FILL: begin
                    s_ready <= 1'b1;
                    if (last_beat) begin
                        state    <= LD_START;
                        ws_start <= 1'b1;
`ifdef IMG_PINGPONG_EN
                        rd_bank  <= wr_bank;
                        wr_bank  <= rd_bank;
`else
                        s_ready  <= 1'b0;
`endif
                    end
                end
                LD_START: begin
                    frame_cnt <= frame_cnt + 16'd1;
                    state     <= LD_WAIT;
`ifdef IMG_PINGPONG_EN
                    if (last_beat) begin
                        wr_full <= 1'b1;
                        s_ready <= 1'b0;
                    end
`endif
                end
                LD_WAIT: begin
`ifdef IMG_PINGPONG_EN
                    // core releases its bank: swap if the other one is ready
                    if (core_done && (wr_full || last_beat)) begin
                        rd_bank  <= wr_bank;
                        wr_bank  <= rd_bank;
                        wr_full  <= 1'b0;
                        s_ready  <= 1'b1;
                        ws_start <= 1'b1;
                        state    <= LD_START;
                    end else if (core_done) begin
                        state <= LD_FILL;
                    end else if (last_beat) begin
                        wr_full <= 1'b1;
                        s_ready <= 1'b0;
                    end
`else
                    if (core_done) begin
                        state   <= LD_FILL;
                        s_ready <= 1'b1;
                    end
`endif
                end
                default: state <= LD_FILL;
            endcase
        end
    end

    image_buffer_ram #(
        .WIDTH(DATA_WIDTH),
        .DEPTH(RAM_DEPTH)
    ) u_ram (
        .clk  (clk),
        .rst  (rst),
        .we   (accept),
        .waddr(ram_waddr),
        .wdata(s_data),
        .re   (ws_ram_r_wen),
        .rzero(rd_oob),
        .raddr(ram_raddr),
        .rdata(ws_ram_r_data)
    );

endmodule

// File: tb/tb_image_buffer_loader.sv
// tb/tb_image_buffer_loader.sv - self-checking bench for image_buffer_loader
// Build with IMG_PINGPONG_EN defined to exercise the double-buffered variant.
module tb_image_buffer_loader;

    localparam int FL = 1024;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [7:0]    s_data;
    logic          s_last;
    logic          ws_start;
    logic [AW-1:0] ws_ram_r_addr;
    logic          ws_ram_r_wen;
    logic [7:0]    ws_ram_r_data;
    logic          core_done;
    logic          frame_err;
    logic [15:0]   frame_cnt;

    int total   = 0;
    int bad     = 0;
    int cyc     = 0;
    int done_at = -1;
    int exp_ptr = 0;
    int ws_cyc  = 0;

    logic [7:0] model_mem [FL];
    logic [7:0] f2 [FL];

    always #5 clk = ~clk;

    image_buffer_loader #(.DATA_ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .ws_start     (ws_start),
        .ws_ram_r_addr(ws_ram_r_addr),
        .ws_ram_r_wen (ws_ram_r_wen),
        .ws_ram_r_data(ws_ram_r_data),
        .core_done    (core_done),
        .frame_err    (frame_err),
        .frame_cnt    (frame_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        core_done = (cyc == done_at);
        @(posedge clk);
        #1;
        cyc++;
        core_done = 1'b0;
    endtask

    function automatic logic [7:0] model_rd(input int a);
        return (a >= FL) ? 8'h00 : model_mem[a];
    endfunction

    task automatic rd(input int a, input logic [7:0] exp, input string tag);
        ws_ram_r_addr = AW'(a);
        ws_ram_r_wen  = 1'b1;
        tick();
        ws_ram_r_wen  = 1'b0;
        chk(tag, ws_ram_r_data, exp);
    endtask

    task automatic send(input logic [7:0] d, input logic last, input logic ws_ok, input string tag);
        logic fin;
        int   n;
        n       = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (s_ready !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        chk({tag, "_ready"}, s_ready, 1);
        fin = (exp_ptr == FL - 1);
        tick();
        model_mem[exp_ptr] = d;
        exp_ptr = (fin || last) ? 0 : exp_ptr + 1;
        chk({tag, "_ws"}, ws_start, fin & ws_ok);
        chk({tag, "_err"}, frame_err, fin ? !last : last);
    endtask

    task automatic stream(input int n, input int last_at, input bit rnd, input logic ws_ok, input string tag);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            d = rnd ? 8'($urandom) : 8'(i);
            send(d, i == last_at, ws_ok, tag);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        logic [7:0] old;
        rst = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        ws_ram_r_addr = '0; ws_ram_r_wen = 1'b0; core_done = 1'b0;
        tick(); tick(); tick();
        chk("rst_ready", s_ready, 0);
        chk("rst_ws", ws_start, 0);
        chk("rst_rdata", ws_ram_r_data, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_cnt", frame_cnt, 0);
        rst = 1'b1;
        tick();
        chk("rel_ready", s_ready, 1);

        // frame of data = address, s_last on the final beat
        stream(FL, FL - 1, 1'b0, 1'b1, "t1");
        ws_cyc = cyc;
        tick();
        chk("t1_ws_single", ws_start, 0);
        chk("t1_cnt", frame_cnt, 1);
        rd(0, model_rd(0), "t1_rd0");
        rd(5, model_rd(5), "t1_rd5");
        rd(1023, model_rd(1023), "t1_rd1023");
        chk("t1_rd1023_const", ws_ram_r_data, 255);

`ifdef IMG_PINGPONG_EN
        // core_done lands mid-fill of frame 2, so the swap waits for its last beat
        done_at = ws_cyc + 300;
        stream(FL, FL - 1, 1'b1, 1'b1, "t6_f2");
        for (int i = 0; i < FL; i++) f2[i] = model_mem[i];
        stream(FL, FL - 1, 1'b1, 1'b0, "t6_f3");
        chk("t6_full_ready", s_ready, 0);
        chk("t6_cnt2", frame_cnt, 2);
        for (int k = 0; k < 4; k++) begin
            a = $urandom_range(0, FL - 1);
            rd(a, f2[a], "t6_rd_f2");
        end
        done_at = cyc;
        tick();
        chk("t6_ws_after_done", ws_start, 1);
        chk("t6_ready_after_swap", s_ready, 1);
        tick();
        chk("t6_ws_pulse", ws_start, 0);
        chk("t6_cnt3", frame_cnt, 3);
        for (int k = 0; k < 4; k++) begin
            a = $urandom_range(0, FL - 1);
            rd(a, model_rd(a), "t6_rd_f3");
        end
`else
        // s_valid held high while the core owns the frame
        s_valid = 1'b1;
        s_data  = 8'($urandom);
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("t3_ready_wait", s_ready, 0);
        end
        done_at = cyc;
        tick();
        chk("t3_ready_after_done", s_ready, 1);
        s_valid = 1'b0;
        done_at = cyc;
        tick();
        chk("t3_done_in_fill_ready", s_ready, 1);
        chk("t3_done_in_fill_ws", ws_start, 0);

        // early s_last, then a frame whose final beat lacks s_last
        stream(11, 10, 1'b1, 1'b1, "t2_early");
        tick();
        chk("t2_err_pulse", frame_err, 0);
        stream(FL, -1, 1'b1, 1'b1, "t2_nolast");
        tick();
        chk("t2_cnt", frame_cnt, 2);
        done_at = cyc;
        tick();
        chk("t2_ready_fill", s_ready, 1);

        for (int k = 0; k < 6; k++) begin
            a = $urandom_range(0, FL - 1);
            rd(a, model_rd(a), "t4_rd");
        end
        a = $urandom_range(0, FL - 1);
        rd(a, model_rd(a), "t4_rd_pre_hold");
        rd(FL + $urandom_range(0, FL - 1), 8'h00, "t4_oob");
        rd(a, model_rd(a), "t4_rd_before_hold");
        ws_ram_r_addr = AW'((a + 1) % FL);
        tick();
        tick();
        chk("t4_hold", ws_ram_r_data, model_rd(a));

        stream(7, -1, 1'b1, 1'b1, "t4_pre");
        old = model_mem[7];
        ws_ram_r_addr = AW'(7);
        ws_ram_r_wen  = 1'b1;
        send(~old, 1'b0, 1'b1, "t4_coll_wr");
        ws_ram_r_wen  = 1'b0;
        s_valid       = 1'b0;
        chk("t4_coll_old", ws_ram_r_data, old);
        rd(7, ~old, "t4_coll_new");

        // reset in the middle of a frame
        stream(492, -1, 1'b1, 1'b1, "t5_part");
        rst = 1'b0;
        #1;
        chk("t5_rst_ready", s_ready, 0);
        chk("t5_rst_ws", ws_start, 0);
        chk("t5_rst_err", frame_err, 0);
        chk("t5_rst_cnt", frame_cnt, 0);
        chk("t5_rst_rdata", ws_ram_r_data, 0);
        tick();
        tick();
        rst = 1'b1;
        exp_ptr = 0;
        tick();
        chk("t5_rel_ready", s_ready, 1);
        stream(FL, FL - 1, 1'b1, 1'b1, "t5_full");
        tick();
        chk("t5_cnt", frame_cnt, 1);
        for (int k = 0; k < 4; k++) begin
            a = $urandom_range(0, FL - 1);
            rd(a, model_rd(a), "t5_rd");
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
